// File: rtl/uart_frame_codec.sv
// uart_frame_codec: header-synchronised framed RX/TX engine between the byte UART paths and the tracker core.
// Frame = HEADER, N payload bytes (big-endian fields), 8-bit additive checksum of the payload.
module uart_frame_codec #(
    parameter int         NUM_FIELDS  = 4,
    parameter int         FIELD_BYTES = 2,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000,
    localparam int        N           = NUM_FIELDS * FIELD_BYTES,
    localparam int        W           = N * 8
) (
    input  logic         iclk,
    input  logic         s_rst,
    input  logic [7:0]   rx_byte_i,
    input  logic         rx_byte_valid_i,
    output logic [W-1:0] rx_fields,
    output logic         rx_over,
    output logic         rx_err,
    input  logic         tx_start,
    input  logic [W-1:0] tx_fields,
    output logic         tx_busy,
    output logic [7:0]   tx_data,
    output logic         tx_en,
    input  logic         tx_done_i,
    output logic         tx_frame_done
);
    localparam int IW = $clog2(N + 1);
    localparam int PW = $clog2(N + 2);
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [1:0] R_HUNT    = 2'd0;
    localparam logic [1:0] R_PAYLOAD = 2'd1;
    localparam logic [1:0] R_CSUM    = 2'd2;
    localparam logic [1:0] T_IDLE    = 2'd0;
    localparam logic [1:0] T_SEND    = 2'd1;
    localparam logic [1:0] T_WAIT    = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_sum;
    logic [W-1:0]  r_stage;
    logic [TW-1:0] r_tmo;

    logic [1:0]    t_state;
    logic [PW-1:0] t_pos;
    logic [7:0]    t_sum;
    logic [W-1:0]  t_buf;

    always_ff @(posedge iclk or posedge s_rst) begin
        if (s_rst) begin
            r_state   <= R_HUNT;
            r_idx     <= '0;
            r_sum     <= '0;
            r_stage   <= '0;
            r_tmo     <= '0;
            rx_fields <= '0;
            rx_over   <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_over <= 1'b0;
            rx_err  <= 1'b0;
            r_tmo   <= (r_state == R_HUNT || rx_byte_valid_i) ? '0 : r_tmo + 1'b1;
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (rx_byte_valid_i) begin
                case (r_state)
                    R_HUNT: if (rx_byte_i == HEADER) begin
                        r_state <= R_PAYLOAD;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                    R_PAYLOAD: begin
                        r_stage <= W'({r_stage, rx_byte_i});
                        r_sum   <= r_sum + rx_byte_i;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == IW'(N - 1)) r_state <= R_CSUM;
                    end
                    default: begin
                        rx_over <= rx_byte_i == r_sum;
                        rx_err  <= rx_byte_i != r_sum;
                        if (rx_byte_i == r_sum) rx_fields <= r_stage;
                        r_state <= R_HUNT;
                    end
                endcase
            end else if (r_state != R_HUNT && TIMEOUT_CYC != 0 && r_tmo == TMO_LAST) begin
                rx_err  <= 1'b1;
                r_state <= R_HUNT;
                r_stage <= '0;
            end
        end
    end

    // tx_data is loaded on entry to T_SEND so the strobe and its byte line up in the same cycle.
    always_ff @(posedge iclk or posedge s_rst) begin
        if (s_rst) begin
            t_state       <= T_IDLE;
            t_pos         <= '0;
            t_sum         <= '0;
            t_buf         <= '0;
            tx_data       <= '0;
            tx_frame_done <= 1'b0;
        end else begin
            tx_frame_done <= 1'b0;
            case (t_state)
                T_IDLE: if (tx_start) begin
                    t_buf   <= tx_fields;
                    t_sum   <= '0;
                    t_pos   <= '0;
                    tx_data <= HEADER;
                    t_state <= T_SEND;
                end
                T_SEND: t_state <= T_WAIT;
                default: if (tx_done_i) begin
                    if (t_pos == PW'(N + 1)) begin
                        tx_frame_done <= 1'b1;
                        t_state       <= T_IDLE;
                    end else begin
                        t_pos   <= t_pos + 1'b1;
                        t_state <= T_SEND;
                        if (t_pos == PW'(N)) begin
                            tx_data <= t_sum;
                        end else begin
                            tx_data <= t_buf[W-1 -: 8];
                            t_sum   <= t_sum + t_buf[W-1 -: 8];
                            t_buf   <= t_buf << 8;
                        end
                    end
                end
            endcase
        end
    end

    assign tx_en   = t_state == T_SEND;
    assign tx_busy = t_state != T_IDLE;
endmodule

// File: tb/tb_uart_frame_codec.sv
// tb_uart_frame_codec: scoreboard bench for uart_frame_codec framing, checksum, timeout, TX handshake and reset.
`timescale 1ns/1ps
module tb_uart_frame_codec;
    logic        iclk = 1'b0;
    logic        s_rst = 1'b1;
    logic [7:0]  rx_byte_i = '0;
    logic        rx_byte_valid_i = 1'b0;
    logic [63:0] rx_fields;
    logic        rx_over, rx_err;
    logic        tx_start = 1'b0;
    logic [63:0] tx_fields = '0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_done_i = 1'b0;
    logic        tx_frame_done;

    logic [7:0]  s_byte = '0;
    logic        s_valid = 1'b0;
    logic [23:0] s_fields;
    logic        s_over, s_err, s_busy, s_en, s_fdone;
    logic [7:0]  s_data;
    logic        s_tx_start = 1'b0;
    logic [23:0] s_tx_fields = '0;
    logic        s_tx_done = 1'b0;

    typedef struct {
        logic        is_err;
        logic [63:0] f;
        int          t;
    } rx_exp_t;

    rx_exp_t     rx_q[$];
    rx_exp_t     me;
    logic [7:0]  tx_q[$];
    int          done_q[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, last_cyc = 0, exp_en_cyc = 0;
    logic [63:0] good = '0;

    uart_frame_codec #(.TIMEOUT_CYC(50)) u_dut (
        .iclk(iclk), .s_rst(s_rst),
        .rx_byte_i(rx_byte_i), .rx_byte_valid_i(rx_byte_valid_i),
        .rx_fields(rx_fields), .rx_over(rx_over), .rx_err(rx_err),
        .tx_start(tx_start), .tx_fields(tx_fields), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_en(tx_en), .tx_done_i(tx_done_i),
        .tx_frame_done(tx_frame_done)
    );

    uart_frame_codec #(.NUM_FIELDS(3), .FIELD_BYTES(1), .TIMEOUT_CYC(50)) u_small (
        .iclk(iclk), .s_rst(s_rst),
        .rx_byte_i(s_byte), .rx_byte_valid_i(s_valid),
        .rx_fields(s_fields), .rx_over(s_over), .rx_err(s_err),
        .tx_start(s_tx_start), .tx_fields(s_tx_fields), .tx_busy(s_busy),
        .tx_data(s_data), .tx_en(s_en), .tx_done_i(s_tx_done),
        .tx_frame_done(s_fdone)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge iclk) begin
        if (!s_rst) begin
            if (rx_over || rx_err) begin
                chk("rx_excl", 64'(rx_over & rx_err), 64'd0);
                if (rx_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rx_unexpected: over=%0b err=%0b, expected no event", rx_over, rx_err);
                end else begin
                    me = rx_q.pop_front();
                    chk("rx_kind", {62'd0, rx_err, rx_over}, me.is_err ? 64'd2 : 64'd1);
                    chk("rx_fields", rx_fields, me.f);
                    if (me.t != 0) chk("rx_err_cycle", 64'(cyc), 64'(me.t));
                end
            end
            if (tx_en) begin
                if (tx_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_unexpected: tx_en with data %0h, expected none", tx_data);
                end else begin
                    chk("tx_data", 64'(tx_data), 64'(tx_q.pop_front()));
                    chk("tx_en_cycle", 64'(cyc), 64'(exp_en_cyc));
                end
            end
            if (tx_frame_done) begin
                if (done_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_done_unexpected: tx_frame_done pulse, expected none");
                end else begin
                    void'(done_q.pop_front());
                    chk("tx_busy_at_done", 64'(tx_busy), 64'd0);
                    chk("tx_bytes_left", 64'(tx_q.size()), 64'd0);
                end
            end
        end
    end

    // Byte-complete responder: tx_done_i 10 cycles after each strobe.
    initial forever begin
        @(negedge iclk);
        if (tx_en) begin
            repeat (10) @(posedge iclk);
            #1 tx_done_i = 1'b1;
            @(posedge iclk);
            #1 tx_done_i = 1'b0;
            exp_en_cyc = cyc;
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        rx_byte_i = b;
        rx_byte_valid_i = 1'b1;
        @(posedge iclk); #1;
        rx_byte_valid_i = 1'b0;
        last_cyc = cyc;
        repeat (gap) begin @(posedge iclk); #1; end
    endtask

    task automatic send_frame(input logic [63:0] f, input logic [7:0] flip, input int slow);
        logic [7:0] b;
        logic [7:0] s;
        s = 8'h00;
        send(8'hA5, 1);
        for (int i = 0; i < 8; i++) begin
            b = f[8*(7-i) +: 8];
            s = s + b;
            send(b, (i == slow) ? 49 : 1);
        end
        rx_q.push_back('{is_err: flip != 0, f: (flip != 0) ? good : f, t: 0});
        if (flip == 0) good = f;
        send(s ^ flip, 2);
    endtask

    task automatic start_tx(input logic [63:0] f, input logic [7:0] cs);
        tx_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) tx_q.push_back(f[8*(7-i) +: 8]);
        tx_q.push_back(cs);
        done_q.push_back(1);
        tx_fields = f;
        tx_start = 1'b1;
        @(posedge iclk); #1;
        tx_start = 1'b0;
        exp_en_cyc = cyc;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((rx_q.size() + tx_q.size() + done_q.size()) != 0 && k < 3000) begin
            @(posedge iclk); #1;
            k++;
        end
        chk(name, 64'(rx_q.size() + tx_q.size() + done_q.size()), 64'd0);
    endtask

    task automatic send_s(input logic [7:0] b);
        s_byte = b;
        s_valid = 1'b1;
        @(posedge iclk); #1;
        s_valid = 1'b0;
        @(posedge iclk); #1;
    endtask

    initial begin
        repeat (2) @(posedge iclk); #1;
        chk("rst_rx_fields", rx_fields, 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_flags", {59'd0, tx_busy, tx_en, tx_frame_done, rx_over, rx_err}, 64'd0);
        s_rst = 1'b0;
        repeat (2) begin @(posedge iclk); #1; end

        send_frame(64'h0010_0020_0030_0040, 8'h00, -1);
        send_frame(64'h0010_0020_0030_0040, 8'h01, -1);
        send(8'h11, 1);
        send(8'h22, 1);
        send_frame(64'h00A5_0001_0002_0003, 8'h00, -1);

        send(8'hA5, 1);
        send(8'h00, 1);
        send(8'h01, 1);
        send(8'h02, 0);
        rx_q.push_back('{is_err: 1'b1, f: good, t: last_cyc + 50});
        repeat (60) begin @(posedge iclk); #1; end
        send_frame(64'h1234_5678_9ABC_DEF0, 8'h00, 3);
        drain("rx_drain");

        start_tx(64'hFFFF_0001_0002_0003, 8'h04);
        repeat (30) begin @(posedge iclk); #1; end
        chk("tx_busy_mid", 64'(tx_busy), 64'd1);
        tx_fields = '0;
        tx_start = 1'b1;
        @(posedge iclk); #1;
        tx_start = 1'b0;
        drain("tx_drain");
        chk("tx_busy_after", 64'(tx_busy), 64'd0);

        start_tx(64'h0102_0304_0506_0708, 8'h24);
        repeat (20) begin @(posedge iclk); #1; end
        send(8'hA5, 1);
        send(8'h01, 1);
        send(8'h02, 1);
        #2 s_rst = 1'b1;
        #1;
        tx_q.delete();
        done_q.delete();
        chk("midrst_rx_fields", rx_fields, 64'd0);
        chk("midrst_tx_data", 64'(tx_data), 64'd0);
        chk("midrst_flags", {59'd0, tx_busy, tx_en, tx_frame_done, rx_over, rx_err}, 64'd0);
        good = '0;
        repeat (15) @(posedge iclk);
        #1 s_rst = 1'b0;
        repeat (2) begin @(posedge iclk); #1; end

        start_tx(64'h0102_0304_0506_0708, 8'h24);
        send_frame(64'h0010_0020_0030_0040, 8'h00, -1);
        drain("post_rst_drain");

        send_s(8'hA5);
        send_s(8'h0A);
        send_s(8'h0B);
        send_s(8'h0C);
        s_byte = 8'h21;
        s_valid = 1'b1;
        @(posedge iclk); #1;
        s_valid = 1'b0;
        chk("small_over", 64'(s_over), 64'd1);
        chk("small_err", 64'(s_err), 64'd0);
        chk("small_fields", 64'(s_fields), 64'h0A0B0C);

        repeat (5) begin @(posedge iclk); #1; end
        drain("final_drain");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_frame_codec.md
Name: uart_frame_codec

Overview:
- Parametrised framed-protocol engine between the byte-level UART paths (uart_rx_path / uart_tx_path) and the tracker core.
- Generalises the fixed 4×16-bit exchange to NUM_FIELDS fields of FIELD_BYTES bytes each.
- Adds a header byte for resynchronisation, an 8-bit additive checksum, an inter-byte RX timeout, an error pulse and a TX busy/done handshake.
- RX and TX are independent state machines sharing one clock.

Parameters:
- NUM_FIELDS, 4: number of fields per frame (1..16).
- FIELD_BYTES, 2: bytes per field, big-endian (1..4).
- HEADER, 8'hA5: frame start byte.
- TIMEOUT_CYC, 100000: max iclk cycles between RX bytes inside a frame; 0 disables the timeout.
- Derived: N = NUM_FIELDS*FIELD_BYTES; W = N*8.

Ports:
- iclk, in, 1: clock.
- s_rst, in, 1: reset, asynchronous, active-high.
- rx_byte_i, in, 8: byte from uart_rx_path.
- rx_byte_valid_i, in, 1: one-cycle strobe, rx_byte_i valid.
- rx_fields, out, W: last good payload; first payload byte in bits [W-1:W-8].
- rx_over, out, 1: one-cycle pulse, rx_fields updated.
- rx_err, out, 1: one-cycle pulse on checksum mismatch or timeout.
- tx_start, in, 1: one-cycle request to send a frame.
- tx_fields, in, W: payload, sampled on the accepted tx_start; same byte order as rx_fields.
- tx_busy, out, 1: TX FSM not idle.
- tx_data, out, 8: byte to uart_tx_path.
- tx_en, out, 1: one-cycle strobe to uart_tx_path.
- tx_done_i, in, 1: byte-complete pulse from uart_tx_path.
- tx_frame_done, out, 1: one-cycle pulse, whole frame sent.

Behaviour:
- Reset (async, any time, mid-frame included):
  - RX -> R_HUNT, TX -> T_IDLE.
  - All outputs 0, including rx_fields.
  - Byte counters, checksum accumulators, staging registers and timeout counter cleared.
- Frame on the wire: HEADER, N payload bytes, CSUM, where CSUM = (sum of the payload bytes) mod 256. The header is not included in the sum.
- RX FSM, acting only on cycles with rx_byte_valid_i=1:
  - R_HUNT: byte==HEADER -> R_PAYLOAD, clear index and sum. Any other byte is discarded silently; no rx_err.
  - R_PAYLOAD: store the byte into staging at index idx (idx 0 is the MSB byte), sum += byte, idx++. After byte N-1 -> R_CSUM.
  - R_CSUM, byte==sum: next cycle rx_fields <= staging, rx_over=1, -> R_HUNT.
  - R_CSUM, byte!=sum: next cycle rx_err=1, rx_fields unchanged, -> R_HUNT.
  - In R_PAYLOAD, a byte equal to HEADER is treated as data (no restart).
- Timeout:
  - Counter runs in R_PAYLOAD/R_CSUM and clears on every rx_byte_valid_i.
  - When it reaches TIMEOUT_CYC: rx_err pulse, -> R_HUNT, staging discarded.
  - A byte and expiry in the same cycle: the byte wins and the counter clears.
  - Counter held at 0 in R_HUNT.
- rx_over and rx_err are never high in the same cycle.
- TX FSM:
  - T_IDLE: tx_start=1 -> latch tx_fields, clear sum, -> T_SEND.
  - T_SEND: tx_en=1 for one cycle with the current byte (header, payload idx 0..N-1, then CSUM). Payload bytes are added to the sum. -> T_WAIT.
  - T_WAIT: on tx_done_i, if the CSUM byte was just sent -> tx_frame_done pulse, -> T_IDLE; otherwise advance -> T_SEND.
- TX latency and handshake:
  - tx_start in cycle 0 gives tx_en with HEADER in cycle 1.
  - Each subsequent tx_en comes 1 cycle after the previous byte's tx_done_i.
  - Total tx_en pulses per frame = N+2.
- tx_busy = (state != T_IDLE); it is 0 in the cycle tx_frame_done pulses (FSM returns to idle).
- tx_start while tx_busy is ignored; the latched payload is not disturbed.
- tx_done_i outside T_WAIT is ignored.
- tx_data holds its last value between strobes; 0 after reset.
- Arithmetic: the sum is 8-bit, wraps mod 256; index counters are sized clog2(N+1).

Test Plan:
- Defaults. RX A5 00 10 00 20 00 30 00 40 A0 -> one rx_over pulse; rx_fields=64'h0010_0020_0030_0040; rx_err=0.
- Same frame with CSUM=A1 -> one rx_err pulse, no rx_over; rx_fields keeps the previous value.
- Garbage 11 22 before A5, then a good frame -> no rx_err for the garbage; frame accepted. A payload byte A5 inside a frame is stored as data.
- TIMEOUT_CYC=50. A5 then 3 bytes, then silence for 50 cycles -> rx_err exactly 50 cycles after the last byte. A following good frame is accepted.
- tx_start with tx_fields=64'hFFFF_0001_0002_0003, bench returns tx_done_i 10 cycles after each tx_en:
  - tx_data sequence A5 FF FF 00 01 00 02 00 03 04 (10 strobes).
  - tx_frame_done once; tx_busy low afterwards.
  - A second tx_start mid-frame has no effect.
- Assert s_rst mid-RX-frame and mid-TX-frame -> all outputs 0 immediately. After release, a fresh RX frame and TX frame complete correctly; NUM_FIELDS=3, FIELD_BYTES=1 build also passes the good-frame case.
